// File: rtl/dct_block_sequencer_pkg.sv
// dct_seq_pkg: sequencer state encoding, block geometry and the ping-pong phase helper.
package dct_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int BLOCK_ROWS = 8;
    function automatic logic [3:0] phase_of(input logic [31:0] k, input logic [31:0] ofs);
        logic [31:0] d;
        d = (k - ofs) % (2 * BLOCK_ROWS);
        return (k < ofs) ? 4'd0 : d[3:0];
    endfunction
endpackage

// File: rtl/dct_block_sequencer_phase_gen.sv
// dct_phase_gen: registered ping-pong select and row index for one transpose stage.
module dct_phase_gen
    import dct_seq_pkg::*;
#(
    parameter int OFS = 0,
    parameter int CW  = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    input  logic [CW-1:0] k,
    output logic          sel,
    output logic [2:0]    row
);
    logic [3:0] ph;
    assign ph = phase_of(32'(k), 32'(OFS));
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            sel <= 1'b0;
            row <= 3'd0;
        end else if (adv) begin
            sel <= ph[3];
            row <= ph[2:0];
        end
    end
endmodule

// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer: start/abort-controlled issue and write-back schedule for the 2-D DCT datapath.
// Optional out_ready stall support is compiled in with DCT_SEQ_BACKPRESSURE_EN.
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int NUM_WORDS = 32768,
    parameter int PIPE_LAT  = 19,
    parameter int TP1_OFS   = 0,
    parameter int TP2_OFS   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef DCT_SEQ_BACKPRESSURE_EN
    input  logic              out_ready,
`endif
    output logic              busy,
    output logic              done,
    output logic              pipe_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tp1_sel,
    output logic              tp2_sel,
    output logic [2:0]        row_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);
    localparam int KW = ADDR_W + 6;
    localparam logic [KW-1:0] LAST_K = KW'(NUM_WORDS - 1);
    localparam logic [KW-1:0] END_K = KW'(PIPE_LAT + NUM_WORDS);
    localparam logic [KW-1:0] LAT = KW'(PIPE_LAT);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_WORDS - 1);
    state_t state, state_n;
    logic [KW-1:0] k, k_n, wk;
    logic go, act_n, clr;
    logic [2:0] unused_row1;
`ifdef DCT_SEQ_BACKPRESSURE_EN
    assign go = out_ready;
`else
    assign go = 1'b1;
`endif
    // k is the slot shown this cycle; it is consumed only when pipe_en was high, so a stall re-presents it
    always_comb begin
        k_n = (state == IDLE) ? '0 : k + KW'(pipe_en);
        state_n = (state == IDLE) ? (start ? RUN : IDLE)
                : (state == DONE) ? IDLE
                : (k_n <= LAST_K) ? RUN
                : (k_n < END_K) ? DRAIN : DONE;
        if (abort) state_n = IDLE;
    end
    assign act_n = (state_n == RUN) || (state_n == DRAIN);
    assign clr = (state_n == IDLE);
    assign wk = k_n - LAT;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pipe_en <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            state   <= state_n;
            k       <= clr ? '0 : k_n;
            busy    <= act_n;
            done    <= (state_n == DONE);
            pipe_en <= act_n && go;
            rd_en   <= (state_n == RUN) && go;
            wr_en   <= act_n && go && (k_n >= LAT);
            rd_addr <= clr ? '0 : (k_n <= LAST_K) ? k_n[ADDR_W-1:0] : LAST_A;
            wr_addr <= (clr || k_n < LAT) ? '0 : (wk <= LAST_K) ? wk[ADDR_W-1:0] : LAST_A;
        end
    end
    dct_phase_gen #(.OFS(TP1_OFS), .CW(KW)) u_stage1 (
        .clk(clk), .reset(reset), .clr(clr), .adv(act_n), .k(k_n),
        .sel(tp1_sel), .row(unused_row1)
    );
    dct_phase_gen #(.OFS(TP2_OFS), .CW(KW)) u_stage2 (
        .clk(clk), .reset(reset), .clr(clr), .adv(act_n), .k(k_n),
        .sel(tp2_sel), .row(row_idx)
    );
endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb_dct_block_sequencer: table vectors plus a slot-index reference model with random start/abort/stall stimulus.
// Build with DCT_SEQ_BACKPRESSURE_EN to exercise the out_ready stall schedule.
module tb_dct_block_sequencer;
    localparam int AW = 8, N = 32, P = 19, O1 = 0, O2 = 9;
`ifdef DCT_SEQ_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    typedef struct {
        int c, rd_en, rd_addr, wr_en, wr_addr, tp1, tp2, row, busy, done;
    } vec_t;
    typedef struct {
        logic [31:0] rd_en, rd_addr, wr_en, wr_addr, tp1, tp2, row, busy, done;
    } cap_t;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic busy, done, pipe_en, rd_en, wr_en, tp1_sel, tp2_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [2:0] row_idx;
    int checks = 0, fails = 0;
    vec_t tbl[16];
    cap_t cap[56];

    always #5 clk = ~clk;

    dct_block_sequencer #(.ADDR_W(AW), .NUM_WORDS(N), .PIPE_LAT(P), .TP1_OFS(O1), .TP2_OFS(O2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef DCT_SEQ_BACKPRESSURE_EN
        .out_ready(out_ready),
`endif
        .busy(busy), .done(done), .pipe_en(pipe_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .tp1_sel(tp1_sel), .tp2_sel(tp2_sel), .row_idx(row_idx), .wr_en(wr_en), .wr_addr(wr_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_opt(input string name, input logic [31:0] act, input int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int ref_sel(input int j, input int ofs);
        return (j < ofs) ? 0 : ((j - ofs) / 8) % 2;
    endfunction

    function automatic int ref_row(input int j, input int ofs);
        return (j < ofs) ? 0 : (j - ofs) % 8;
    endfunction

    function automatic bit pick_stall(input int c, input int lo, input int hi, input bit rnd);
        return BP && ((c >= lo && c <= hi) || (rnd && $urandom_range(0, 3) == 0));
    endfunction

    // j = number of slots already consumed; a frame is N+P slots long, then one done cycle
    task automatic check_slot(input int c, input int j, input bit st);
        bit act;
        act = (j < N + P);
        chk($sformatf("busy@%0d", c), busy, int'(act));
        chk($sformatf("done@%0d", c), done, int'(!act));
        chk($sformatf("pipe_en@%0d", c), pipe_en, int'(act && !st));
        chk($sformatf("rd_en@%0d", c), rd_en, int'(act && !st && j < N));
        chk($sformatf("wr_en@%0d", c), wr_en, int'(act && !st && j >= P));
        if (act) begin
            chk($sformatf("rd_addr@%0d", c), rd_addr, (j < N) ? j : N - 1);
            chk($sformatf("wr_addr@%0d", c), wr_addr, (j < P) ? 0 : ((j - P < N) ? j - P : N - 1));
            chk($sformatf("tp1_sel@%0d", c), tp1_sel, ref_sel(j, O1));
            chk($sformatf("tp2_sel@%0d", c), tp2_sel, ref_sel(j, O2));
            chk($sformatf("row_idx@%0d", c), row_idx, ref_row(j, O2));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
    endtask

    task automatic run_frame(input int abort_at, input int start_at, input int lo, input int hi,
                             input bit rnd, input bit start_in_done);
        int j, ns, c;
        bit st, fin;
        j = 0; ns = 0; c = 0; fin = 1'b0;
        st = pick_stall(0, lo, hi, rnd);
        out_ready = !st;
        start = 1'b1;
        step();
        while (c < 400 && !fin) begin
            check_slot(c, j, st);
            if (j == N + P) begin
                fin = 1'b1;
                chk("done_cycle", c, N + P + ns);
            end else if (st) ns++;
            else j++;
            if (c == abort_at) begin
                abort = 1'b1;
                step();
                repeat (3) begin
                    check_idle("abort");
                    step();
                end
                out_ready = 1'b1;
                return;
            end
            c++;
            st = pick_stall(c, lo, hi, rnd);
            out_ready = !st;
            start = fin ? start_in_done : (c == start_at || (rnd && $urandom_range(0, 9) == 0));
            step();
        end
        out_ready = 1'b1;
        chk("frame_end", fin, 1);
        repeat (2) begin
            check_idle("post_done");
            step();
        end
    endtask

    initial begin
        tbl = '{
            '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0},
            '{7, 1, 7, 0, 0, 0, 0, 0, 1, 0},
            '{8, 1, 8, 0, 0, 1, 0, 0, 1, 0},
            '{9, 1, 9, 0, 0, 1, 0, 0, 1, 0},
            '{12, 1, 12, 0, 0, 1, 0, 3, 1, 0},
            '{16, 1, 16, 0, 0, 0, 0, 7, 1, 0},
            '{17, 1, 17, 0, 0, 0, 1, 0, 1, 0},
            '{19, 1, 19, 1, 0, 0, 1, 2, 1, 0},
            '{24, 1, 24, 1, 5, 1, 1, 7, 1, 0},
            '{25, 1, 25, 1, 6, 1, 0, 0, 1, 0},
            '{31, 1, 31, 1, 12, 1, 0, 6, 1, 0},
            '{32, 0, 31, 1, 13, 0, 0, 7, 1, 0},
            '{40, 0, 31, 1, 21, 1, 1, 7, 1, 0},
            '{50, 0, 31, 1, 31, 0, 1, 1, 1, 0},
            '{51, 0, -1, 0, -1, -1, -1, -1, 0, 1},
            '{52, 0, -1, 0, -1, -1, -1, -1, 0, 0}
        };
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pipe_en", pipe_en, 0);
        chk("rst_rd_en", rd_en, 0); chk("rst_rd_addr", rd_addr, 0); chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0); chk("rst_tp1", tp1_sel, 0); chk("rst_tp2", tp2_sel, 0);
        chk("rst_row", row_idx, 0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            step();
            check_idle("after_reset");
        end

        start = 1'b1;
        step();
        for (int c = 0; c < 56; c++) begin
            cap[c].rd_en = 32'(rd_en); cap[c].rd_addr = 32'(rd_addr);
            cap[c].wr_en = 32'(wr_en); cap[c].wr_addr = 32'(wr_addr);
            cap[c].tp1 = 32'(tp1_sel); cap[c].tp2 = 32'(tp2_sel); cap[c].row = 32'(row_idx);
            cap[c].busy = 32'(busy); cap[c].done = 32'(done);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            chk_opt($sformatf("tbl%0d_rd_en", tbl[i].c), cap[tbl[i].c].rd_en, tbl[i].rd_en);
            chk_opt($sformatf("tbl%0d_rd_addr", tbl[i].c), cap[tbl[i].c].rd_addr, tbl[i].rd_addr);
            chk_opt($sformatf("tbl%0d_wr_en", tbl[i].c), cap[tbl[i].c].wr_en, tbl[i].wr_en);
            chk_opt($sformatf("tbl%0d_wr_addr", tbl[i].c), cap[tbl[i].c].wr_addr, tbl[i].wr_addr);
            chk_opt($sformatf("tbl%0d_tp1", tbl[i].c), cap[tbl[i].c].tp1, tbl[i].tp1);
            chk_opt($sformatf("tbl%0d_tp2", tbl[i].c), cap[tbl[i].c].tp2, tbl[i].tp2);
            chk_opt($sformatf("tbl%0d_row", tbl[i].c), cap[tbl[i].c].row, tbl[i].row);
            chk_opt($sformatf("tbl%0d_busy", tbl[i].c), cap[tbl[i].c].busy, tbl[i].busy);
            chk_opt($sformatf("tbl%0d_done", tbl[i].c), cap[tbl[i].c].done, tbl[i].done);
        end

        run_frame(-1, 5, -1, -1, 1'b0, 1'b1);
        run_frame(25, -1, -1, -1, 1'b0, 1'b0);
        run_frame(-1, -1, -1, -1, 1'b0, 1'b0);
`ifdef DCT_SEQ_BACKPRESSURE_EN
        run_frame(-1, -1, 10, 13, 1'b0, 1'b0);
`endif
        for (int f = 0; f < 8; f++) begin
            run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N + P - 1)) : -1,
                      int'($urandom_range(1, N + P - 1)), -1, -1, 1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
